// File: rtl/rsa_exp_sequencer_pkg.sv
// Shared types and constants for the RSA exponentiation control path.
// Holds operand-select codes, sequencer states and CSR byte offsets.
package rsa_pkg;

    typedef enum logic [2:0] {
        OP_M   = 3'd0,
        OP_ACC = 3'd1,
        OP_XT  = 3'd2,
        OP_R2N = 3'd3,
        OP_ONE = 3'd4,
        OP_RN  = 3'd5
    } op_sel_t;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_XT     = 4'd1,
        S_W_XT   = 4'd2,
        S_SQ     = 4'd3,
        S_W_SQ   = 4'd4,
        S_MUL    = 4'd5,
        S_W_MUL  = 4'd6,
        S_NEXT   = 4'd7,
        S_POST   = 4'd8,
        S_W_POST = 4'd9,
        S_DONE   = 4'd10,
        S_ERR    = 4'd11
    } seq_state_t;

    localparam logic [7:0] CSR_COMMAND = 8'd0;
    localparam logic [7:0] CSR_RXADDR  = 8'd4;
    localparam logic [7:0] CSR_TXADDR  = 8'd8;
    localparam logic [7:0] CSR_T       = 8'd12;
    localparam logic [7:0] CSR_T_LEN   = 8'd16;
    localparam logic [7:0] CSR_LOADING = 8'd20;

endpackage

// File: rtl/rsa_exp_sequencer.sv
// Left-to-right Montgomery exponentiation scheduler: issues one multiplication
// at a time to the shared multiplier and steers its operands and writeback.
module rsa_exp_sequencer
    import rsa_pkg::*;
#(
    parameter int EXP_W = 32,
    parameter int LEN_W = 6
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [EXP_W-1:0] exponent,
    input  logic [LEN_W-1:0] exp_len,
    input  logic [2:0]       loaded,
    input  logic             mont_done,
    output logic             mont_start,
    output logic [2:0]       a_sel,
    output logic [2:0]       b_sel,
    output logic             acc_init,
    output logic             we_xt,
    output logic             we_acc,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [15:0]      mul_count
);

    seq_state_t       state;
    seq_state_t       state_nx;
    op_sel_t          a_op;
    op_sel_t          b_op;
    logic             start_q;
    logic             launch;
    logic             launch_ok;
    logic [EXP_W-1:0] exp_reg;
    logic             len_zero;
    logic [LEN_W-1:0] bit_idx;
    logic             cur_bit;
    logic             issue;

    assign launch    = (state == S_IDLE) && start && !start_q;
    assign launch_ok = (loaded == 3'b111) && (exp_len <= LEN_W'(EXP_W));
    assign cur_bit   = |(exp_reg & (EXP_W'(1) << bit_idx));

    // NOTE: reset is sampled on the clock edge, and every sequential register
    // uses non-blocking assignment so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // NOTE: state_nx gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:   if (launch) state_nx = launch_ok ? S_XT : S_ERR;
            S_ERR:    if (!start) state_nx = S_IDLE;
            S_XT:     state_nx = S_W_XT;
            S_W_XT:   if (mont_done) state_nx = len_zero ? S_POST : S_SQ;
            S_SQ:     state_nx = S_W_SQ;
            S_W_SQ:   if (mont_done) state_nx = cur_bit ? S_MUL : S_NEXT;
            S_MUL:    state_nx = S_W_MUL;
            S_W_MUL:  if (mont_done) state_nx = S_NEXT;
            S_NEXT:   state_nx = (bit_idx == '0) ? S_POST : S_SQ;
            S_POST:   state_nx = S_W_POST;
            S_W_POST: if (mont_done) state_nx = start ? S_DONE : S_IDLE;
            S_DONE:   if (!start) state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    // Operand codes are driven in the issue cycle and held through its wait state.
    always_comb begin
        a_op  = OP_M;
        b_op  = OP_M;
        issue = 1'b0;
        busy  = 1'b1;
        done  = 1'b0;
        error = 1'b0;
        unique case (state)
            S_XT, S_W_XT: begin
                a_op = OP_M;
                b_op = OP_R2N;
            end
            S_SQ, S_W_SQ: begin
                a_op = OP_ACC;
                b_op = OP_ACC;
            end
            S_MUL, S_W_MUL: begin
                a_op = OP_ACC;
                b_op = OP_XT;
            end
            S_POST, S_W_POST: begin
                a_op = OP_ACC;
                b_op = OP_ONE;
            end
            S_IDLE: busy = 1'b0;
            S_DONE: begin
                busy = 1'b0;
                done = 1'b1;
            end
            S_ERR: begin
                busy  = 1'b0;
                error = 1'b1;
            end
            default: ;
        endcase
        if (state == S_XT || state == S_SQ || state == S_MUL || state == S_POST) begin
            issue = 1'b1;
        end
    end

    assign mont_start = issue;
    assign a_sel      = a_op;
    assign b_sel      = b_op;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            start_q   <= 1'b0;
            exp_reg   <= '0;
            len_zero  <= 1'b0;
            bit_idx   <= '0;
            mul_count <= '0;
            acc_init  <= 1'b0;
            we_xt     <= 1'b0;
            we_acc    <= 1'b0;
        end else begin
            start_q  <= start;
            acc_init <= launch && launch_ok;
            we_xt    <= mont_done && (state == S_W_XT);
            we_acc   <= mont_done && (state == S_W_SQ || state == S_W_MUL ||
                                      state == S_W_POST);
            if (launch && launch_ok) begin
                exp_reg   <= exponent;
                len_zero  <= (exp_len == '0);
                bit_idx   <= exp_len - LEN_W'(1);
                mul_count <= '0;
            end else begin
                if (issue) mul_count <= mul_count + 16'd1;
                if (state == S_NEXT && bit_idx != '0) bit_idx <= bit_idx - LEN_W'(1);
            end
        end
    end

endmodule
